// File: rtl/drum_pkg.sv
// Shared width helpers for the DRUM multiplier family.
//   drum_prod_w : product width of an N x M DRUM multiplier (N+M)
//   drum_acc_w  : accumulator width that absorbs 2^LEN_W products without overflow
// Used by the accumulator, the multiplier wrapper and later MAC arrays.
package drum_pkg;

    function automatic int drum_prod_w(input int n, input int m);
        return n + m;
    endfunction

    function automatic int drum_acc_w(input int n, input int m, input int len_w);
        return n + m + len_w;
    endfunction

endpackage

// File: rtl/drum_dot_accumulator.sv
// drum_dot_accumulator
// Sums a stream of DRUM products into one dot product per vector. A vector
// ends on in_last, or is closed early once it reaches 2^LEN_W beats. The
// finished sum sits in a one-entry output register until it is drained.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset, discards any partial vector
//   in_valid   - product beat present
//   in_ready   - beat accepted this cycle when in_valid is also high
//   in_prod    - product, N+M bits (signed when SIGNED=1)
//   in_last    - beat closes the vector
//   out_valid  - result register holds a finished sum
//   out_ready  - downstream takes the result
//   out_sum    - dot product, N+M+LEN_W bits
//   out_len    - beats in the vector, 1..2^LEN_W
//   out_forced - vector closed by the length limit, not by in_last
module drum_dot_accumulator
    import drum_pkg::*;
#(
    parameter int N      = 16,
    parameter int M      = 16,
    parameter int LEN_W  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [drum_prod_w(N, M)-1:0]        in_prod,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [drum_acc_w(N, M, LEN_W)-1:0]  out_sum,
    output logic [LEN_W:0]                      out_len,
    output logic                                out_forced
);

    localparam int PW = drum_prod_w(N, M);
    localparam int AW = drum_acc_w(N, M, LEN_W);
    localparam int CW = LEN_W + 1;

    // Count value seen on the beat that fills the vector to 2^LEN_W.
    localparam logic [CW-1:0] CNT_LIMIT = {1'b0, {LEN_W{1'b1}}};

    logic [AW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic [AW-1:0] sum_reg;
    logic [CW-1:0] len_reg;
    logic          forced_reg;
    logic          valid_reg;

    logic [AW-1:0] ext_prod;
    logic [AW-1:0] sum_next;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic          at_limit;
    logic          final_beat;
    logic          drain;

    // Widen the product bit by bit: low bits pass through, upper bits are
    // either copies of the product sign bit or zero.
    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_ext
            if (gi < PW) begin : g_low
                assign ext_prod[gi] = in_prod[gi];
            end else if (SIGNED) begin : g_sign
                assign ext_prod[gi] = in_prod[PW-1];
            end else begin : g_zero
                assign ext_prod[gi] = 1'b0;
            end
        end
    endgenerate

    // Backpressure only while a result is waiting and not being taken.
    assign in_ready   = !valid_reg || out_ready;
    assign accept     = in_valid && in_ready;
    assign at_limit   = (cnt_reg == CNT_LIMIT);
    assign final_beat = accept && (in_last || at_limit);
    assign drain      = valid_reg && out_ready;

    assign sum_next   = acc_reg + ext_prod;
    assign cnt_inc    = cnt_reg + CW'(1);

    // Running accumulator and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (final_beat) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_inc;
        end
    end

    // Result register. A final beat arriving while the old result drains
    // overwrites it directly, so valid never drops between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg    <= '0;
            len_reg    <= '0;
            forced_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else if (final_beat) begin
            sum_reg    <= sum_next;
            len_reg    <= cnt_inc;
            forced_reg <= !in_last;
            valid_reg  <= 1'b1;
        end else if (drain) begin
            valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = valid_reg;
    assign out_sum    = sum_reg;
    assign out_len    = len_reg;
    assign out_forced = forced_reg;

endmodule

// File: tb/tb_drum_dot_accumulator.sv
module tb_drum_dot_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters, signed, LEN_W=8
    logic        a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
    logic [31:0] a_in_prod = 0;
    logic        a_in_ready, a_out_valid, a_out_forced;
    logic [39:0] a_out_sum;
    logic [8:0]  a_out_len;

    drum_dot_accumulator #(.N(16), .M(16), .LEN_W(8), .SIGNED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_len(a_out_len), .out_forced(a_out_forced)
    );

    // Instance B: LEN_W=2, exercises the length limit
    logic        b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
    logic [31:0] b_in_prod = 0;
    logic        b_in_ready, b_out_valid, b_out_forced;
    logic [33:0] b_out_sum;
    logic [2:0]  b_out_len;

    drum_dot_accumulator #(.N(16), .M(16), .LEN_W(2), .SIGNED(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_len(b_out_len), .out_forced(b_out_forced)
    );

    // Instance C: unsigned products
    logic        c_in_valid = 0, c_in_last = 0, c_out_ready = 0;
    logic [31:0] c_in_prod = 0;
    logic        c_in_ready, c_out_valid, c_out_forced;
    logic [39:0] c_out_sum;
    logic [8:0]  c_out_len;

    drum_dot_accumulator #(.N(16), .M(16), .LEN_W(8), .SIGNED(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_prod(c_in_prod), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_sum(c_out_sum), .out_len(c_out_len), .out_forced(c_out_forced)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for instance A: the beats of the open vector are kept
    // in a queue and summed arithmetically when the vector closes.
    localparam int A_LIMIT = 256;
    longint q[$];
    bit     m_valid = 0;
    longint m_sum = 0;
    int     m_len = 0;
    bit     m_forced = 0;

    task automatic a_check_out(input string tag);
        check({tag, ".valid"}, 64'(a_out_valid), 64'(m_valid));
        if (m_valid) begin
            check({tag, ".sum"}, 64'(a_out_sum), {24'b0, m_sum[39:0]});
            check({tag, ".len"}, 64'(a_out_len), 64'(m_len));
            check({tag, ".forced"}, 64'(a_out_forced), 64'(m_forced));
        end
    endtask

    task automatic step_a(input string tag, input bit v, input logic [31:0] p,
                          input bit last, input bit ordy);
        bit exp_ready;
        longint s;
        a_in_valid  = v;
        a_in_prod   = p;
        a_in_last   = last;
        a_out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        check({tag, ".in_ready"}, 64'(a_in_ready), 64'(exp_ready));
        if (v && exp_ready) begin
            q.push_back(longint'($signed(p)));
            if (last || q.size() == A_LIMIT) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_sum    = s;
                m_len    = q.size();
                m_forced = !last;
                m_valid  = 1;
                q.delete();
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        a_check_out(tag);
        $display("A %s: v=%0b prod=%0d last=%0b ordy=%0b -> out_valid=%0b sum=%0d len=%0d forced=%0b",
                 tag, v, $signed(p), last, ordy, a_out_valid, $signed(a_out_sum), a_out_len, a_out_forced);
    endtask

    task automatic step_b(input bit v, input logic [31:0] p, input bit last, input bit ordy);
        b_in_valid = v; b_in_prod = p; b_in_last = last; b_out_ready = ordy;
        @(posedge clk);
        #1;
        $display("B: v=%0b prod=%0d last=%0b -> out_valid=%0b sum=%0d len=%0d forced=%0b",
                 v, $signed(p), last, b_out_valid, $signed(b_out_sum), b_out_len, b_out_forced);
    endtask

    task automatic step_c(input bit v, input logic [31:0] p, input bit last, input bit ordy);
        c_in_valid = v; c_in_prod = p; c_in_last = last; c_out_ready = ordy;
        @(posedge clk);
        #1;
        $display("C: v=%0b prod=%0h last=%0b -> out_valid=%0b sum=%0h len=%0d",
                 v, p, last, c_out_valid, c_out_sum, c_out_len);
    endtask

    initial begin
        // Reset
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        check("rst.a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst.a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst.a_out_sum", 64'(a_out_sum), 64'd0);
        check("rst.a_out_len", 64'(a_out_len), 64'd0);
        check("rst.a_out_forced", 64'(a_out_forced), 64'd0);
        check("rst.b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst.c_out_sum", 64'(c_out_sum), 64'd0);
        @(posedge clk);
        #1;

        // Three-beat vector 100, -30, 5
        step_a("vec3.b0", 1, 32'd100, 0, 1);
        step_a("vec3.b1", 1, -32'sd30, 0, 1);
        step_a("vec3.b2", 1, 32'd5, 1, 1);
        check("vec3.sum", 64'(a_out_sum), 64'd75);

        // Back-to-back single-beat vectors
        step_a("single.m7", 1, -32'sd7, 1, 1);
        check("single.m7.sum", 64'(a_out_sum), 64'hFF_FFFF_FFF9);
        step_a("single.p9", 1, 32'd9, 1, 1);
        check("single.p9.sum", 64'(a_out_sum), 64'd9);
        step_a("idle", 0, 32'd0, 0, 1);

        // Backpressure, then drain and a new final beat in the same cycle
        step_a("bp.res", 1, 32'd1, 1, 0);
        step_a("bp.hold0", 1, 32'd50, 0, 0);
        step_a("bp.hold1", 1, 32'd50, 0, 0);
        step_a("bp.swap", 1, 32'd3, 1, 1);
        check("bp.swap.sum", 64'(a_out_sum), 64'd3);
        step_a("bp.drain", 0, 32'd0, 0, 1);

        // Reset mid-vector discards the partial sum
        step_a("rstv.b0", 1, 32'd11, 0, 1);
        step_a("rstv.b1", 1, 32'd22, 0, 1);
        rst_n = 0;
        q.delete();
        m_valid = 0;
        #2;
        check("rstv.async_sum", 64'(a_out_sum), 64'd0);
        check("rstv.async_valid", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        step_a("rstv.b4", 1, 32'd4, 1, 1);
        check("rstv.sum", 64'(a_out_sum), 64'd4);
        check("rstv.len", 64'(a_out_len), 64'd1);

        // Length limit on the default instance
        for (int i = 0; i < 258; i++) step_a("limit", 1, 32'($urandom), 0, 1);
        step_a("limit.end", 1, 32'd2, 1, 1);

        // LEN_W=2: six beats of 1, no last, then a closing beat of 0
        for (int i = 0; i < 4; i++) step_b(1, 32'd1, 0, 1);
        check("b.forced.valid", 64'(b_out_valid), 64'd1);
        check("b.forced.sum", 64'(b_out_sum), 64'd4);
        check("b.forced.len", 64'(b_out_len), 64'd4);
        check("b.forced.flag", 64'(b_out_forced), 64'd1);
        step_b(1, 32'd1, 0, 1);
        check("b.drained", 64'(b_out_valid), 64'd0);
        step_b(1, 32'd1, 0, 1);
        step_b(1, 32'd0, 1, 1);
        check("b.rest.sum", 64'(b_out_sum), 64'd2);
        check("b.rest.len", 64'(b_out_len), 64'd3);
        check("b.rest.flag", 64'(b_out_forced), 64'd0);
        step_b(0, 32'd0, 0, 1);

        // Unsigned: 0xFFFFFFFF twice
        step_c(1, 32'hFFFF_FFFF, 0, 1);
        step_c(1, 32'hFFFF_FFFF, 1, 1);
        check("c.sum", 64'(c_out_sum), 64'h1_FFFF_FFFE);
        check("c.len", 64'(c_out_len), 64'd2);
        step_c(0, 32'd0, 0, 1);

        // Randomized traffic on instance A
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($signed(8'($urandom)));
            step_a("rand", ($urandom_range(0, 3) != 0), p,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
